// File: rtl/clock_set_if.sv
// Button codes in, counter/display controls out, between the
// debouncers and the time counter.
interface clock_set_if;
    logic [1:0] i_mode_sw;
    logic [1:0] i_adj_sw;
    logic [1:0] o_field;
    logic       o_inc;
    logic       o_dec;
    logic       o_sec_clr;
    logic       o_run;
    logic       o_blink;

    modport master (
        output i_mode_sw, i_adj_sw,
        input  o_field, o_inc, o_dec, o_sec_clr, o_run, o_blink
    );

    modport slave (
        input  i_mode_sw, i_adj_sw,
        output o_field, o_inc, o_dec, o_sec_clr, o_run, o_blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: field select, inc/dec/clear pulses,
// run/halt, blink and idle auto-return driven by MODE/ADJ codes.
module clock_set_ctrl #(
    parameter int unsigned DIV_CONST = 50_000_000,
    parameter int unsigned REPEAT_HZ = 8,
    parameter int unsigned BLINK_HZ  = 2,
    parameter int unsigned IDLE_SEC  = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    clock_set_if.slave bus
);
    localparam logic [63:0] IDLE_LIM  = 64'(IDLE_SEC) * 64'(DIV_CONST);
    localparam logic [31:0] IDLE_MAX  = IDLE_LIM[31:0] - 32'd1;
    localparam logic [31:0] REP_MAX   = 32'(DIV_CONST / REPEAT_HZ - 1);
    localparam logic [31:0] BLINK_MAX = 32'(DIV_CONST / (2 * BLINK_HZ) - 1);

    if (IDLE_LIM > 64'h0000_0000_FFFF_FFFF) begin : g_idle_chk
        $error("IDLE_SEC*DIV_CONST does not fit the 32-bit idle counter");
    end

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HOUR = 2'b01,
        S_MIN  = 2'b10,
        S_SEC  = 2'b11
    } state_t;

    state_t      state, state_nx, short_nx;
    logic [1:0]  mode_prev, adj_prev;
    logic [31:0] rep_cnt, blink_cnt, idle_cnt;
    logic        mode_short, mode_long, mode_held;
    logic        adj_short, adj_long, adj_held;
    logic        mode_ev, any_ev, set_hm, state_chg;
    logic        timeout, rep_hit;
    logic        inc_nx, dec_nx, clr_nx;
    logic        inc_q, dec_q, clr_q, blink_q;

    assign mode_short = (bus.i_mode_sw == 2'b10) && (mode_prev != 2'b10);
    assign mode_long  = (bus.i_mode_sw == 2'b01) && (mode_prev != 2'b01);
    assign mode_held  = (bus.i_mode_sw == 2'b00);
    assign adj_short  = (bus.i_adj_sw == 2'b10) && (adj_prev != 2'b10);
    assign adj_long   = (bus.i_adj_sw == 2'b01) && (adj_prev != 2'b01);
    assign adj_held   = (bus.i_adj_sw == 2'b00);

    assign mode_ev = mode_short | mode_long;
    assign any_ev  = mode_ev | mode_held | adj_short | adj_long | adj_held;
    assign set_hm  = (state == S_HOUR) || (state == S_MIN);
    // Any button activity this cycle outranks the idle timeout.
    assign timeout = (state != S_RUN) && (idle_cnt == IDLE_MAX) && !any_ev;
    assign rep_hit = set_hm && adj_held && (rep_cnt == REP_MAX);

    always_comb begin
        short_nx = S_HOUR;
        unique case (state)
            S_HOUR:  short_nx = S_MIN;
            S_MIN:   short_nx = S_SEC;
            default: short_nx = S_HOUR;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            mode_short: state_nx = short_nx;
            mode_long:  state_nx = S_RUN;
            timeout:    state_nx = S_RUN;
            default:    state_nx = state;
        endcase
    end

    assign state_chg = (state_nx != state);

    always_comb begin
        inc_nx = 1'b0;
        dec_nx = 1'b0;
        clr_nx = 1'b0;
        if (!mode_ev) begin
            inc_nx = set_hm && (adj_short || rep_hit);
            dec_nx = set_hm && adj_long;
            clr_nx = (state == S_SEC) && (adj_short || adj_long);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_RUN;
            mode_prev <= 2'b11;
            adj_prev  <= 2'b11;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            mode_prev <= bus.i_mode_sw;
            adj_prev  <= bus.i_adj_sw;
            inc_q     <= inc_nx;
            dec_q     <= dec_nx;
            clr_q     <= clr_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt <= '0;
        end else if (!adj_held || !set_hm || state_chg || rep_hit) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else if (state_nx == S_RUN || state_chg || any_ev) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (state_nx == S_RUN || state_chg) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end

    assign bus.o_field   = state;
    assign bus.o_inc     = inc_q;
    assign bus.o_dec     = dec_q;
    assign bus.o_sec_clr = clr_q;
    assign bus.o_run     = (state != S_SEC);
    assign bus.o_blink   = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with a cycle-level reference
// model built from edge counts, plus literal spot checks.
module tb_clock_set_ctrl;
    localparam int DIV     = 40;
    localparam int REP_P   = DIV / 8;
    localparam int BLINK_P = DIV / 4;
    localparam int IDLE_L  = 10 * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    clock_set_if bus();

    clock_set_ctrl #(
        .DIV_CONST(DIV),
        .REPEAT_HZ(8),
        .BLINK_HZ(2),
        .IDLE_SEC(10)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: state expressed as counts of edges
    logic [1:0] m_field, pm, pa, nf;
    logic       m_inc, m_dec, m_clr;
    int         hold_len, quiet, since;
    logic       ms, ml, mh, as_, al, ah, any_e, mev, hm, chg, rep;
    logic       inc_n, dec_n, clr_n;
    int         quiet_n, hold_n, since_n, quiet_nn;

    always_comb begin
        ms    = bus.i_mode_sw == 2'b10 && pm != 2'b10;
        ml    = bus.i_mode_sw == 2'b01 && pm != 2'b01;
        mh    = bus.i_mode_sw == 2'b00;
        as_   = bus.i_adj_sw == 2'b10 && pa != 2'b10;
        al    = bus.i_adj_sw == 2'b01 && pa != 2'b01;
        ah    = bus.i_adj_sw == 2'b00;
        any_e = ms | ml | mh | as_ | al | ah;
        mev   = ms | ml;
        hm    = (m_field == 2'd1) || (m_field == 2'd2);
        quiet_n = any_e ? 0 : quiet + 1;
        nf = m_field;
        if (ms)
            nf = (m_field == 2'd1) ? 2'd2 : (m_field == 2'd2) ? 2'd3 : 2'd1;
        else if (ml)
            nf = 2'd0;
        else if (m_field != 2'd0 && quiet_n >= IDLE_L)
            nf = 2'd0;
        chg      = nf != m_field;
        hold_n   = (ah && hm && !chg) ? hold_len + 1 : 0;
        rep      = hold_n > 0 && (hold_n % REP_P) == 0;
        inc_n    = hm && !mev && (as_ || rep);
        dec_n    = hm && !mev && al;
        clr_n    = m_field == 2'd3 && !mev && (as_ || al);
        since_n  = (chg || nf == 2'd0) ? 0 : since + 1;
        quiet_nn = (chg || nf == 2'd0) ? 0 : quiet_n;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_field  <= 2'd0;
            pm       <= 2'b11;
            pa       <= 2'b11;
            m_inc    <= 1'b0;
            m_dec    <= 1'b0;
            m_clr    <= 1'b0;
            hold_len <= 0;
            quiet    <= 0;
            since    <= 0;
        end else begin
            m_field  <= nf;
            pm       <= bus.i_mode_sw;
            pa       <= bus.i_adj_sw;
            m_inc    <= inc_n;
            m_dec    <= dec_n;
            m_clr    <= clr_n;
            hold_len <= hold_n;
            quiet    <= quiet_nn;
            since    <= since_n;
        end
    end

    always @(negedge clk) begin
        logic [6:0] act, exp_v;
        logic       blink_e;
        if (cmp_en) begin
            blink_e = (m_field == 2'd0) ? 1'b1 : (((since / BLINK_P) % 2) == 0);
            exp_v = {m_field, m_inc, m_dec, m_clr, m_field != 2'd3, blink_e};
            act = {bus.o_field, bus.o_inc, bus.o_dec, bus.o_sec_clr,
                   bus.o_run, bus.o_blink};
            checks = checks + 1;
            if (act !== exp_v) begin
                failures = failures + 1;
                $display("FAIL model t=%0t: got %b want %b", $time, act, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d want %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(input logic [1:0] m, input logic [1:0] a);
        bus.i_mode_sw = m;
        bus.i_adj_sw  = a;
        @(negedge clk);
    endtask

    task automatic release_btns();
        bus.i_mode_sw = 2'b11;
        bus.i_adj_sw  = 2'b11;
        @(negedge clk);
    endtask

    task automatic wait_run(input int k0, output int k);
        k = k0;
        while (bus.o_field != 2'b00 && k < 1000) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int n, k;
        bus.i_mode_sw = 2'b11;
        bus.i_adj_sw  = 2'b11;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_field", int'(bus.o_field), 0);
        chk("rst_run", int'(bus.o_run), 1);
        chk("rst_blink", int'(bus.o_blink), 1);
        chk("rst_pulses", int'({bus.o_inc, bus.o_dec, bus.o_sec_clr}), 0);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // 1: enter HOUR, blink half-period of 10 cycles
        press(2'b10, 2'b11);
        chk("t1_field", int'(bus.o_field), 1);
        chk("t1_run", int'(bus.o_run), 1);
        release_btns();
        repeat (8) tick();
        chk("t1_blink_k9", int'(bus.o_blink), 1);
        tick();
        chk("t1_blink_k10", int'(bus.o_blink), 0);

        // 2: single inc, single dec, held short gives one inc
        press(2'b11, 2'b10);
        chk("t2_inc", int'(bus.o_inc), 1);
        release_btns();
        chk("t2_inc_off", int'(bus.o_inc), 0);
        press(2'b11, 2'b01);
        chk("t2_dec", int'(bus.o_dec), 1);
        release_btns();
        n = 0;
        bus.i_adj_sw = 2'b10;
        repeat (3) begin
            tick();
            n += int'(bus.o_inc);
        end
        release_btns();
        n += int'(bus.o_inc);
        chk("t2_held_short_incs", n, 1);

        // 3: MIN, auto-repeat every 5 cycles of HELD
        press(2'b10, 2'b11);
        chk("t3_field", int'(bus.o_field), 2);
        release_btns();
        bus.i_adj_sw = 2'b00;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n += int'(bus.o_inc);
            if (i % 5 == 0) chk("t3_rep_pulse", int'(bus.o_inc), 1);
        end
        chk("t3_rep_count", n, 4);
        release_btns();
        n = int'(bus.o_inc);
        repeat (9) begin
            tick();
            n += int'(bus.o_inc);
        end
        chk("t3_after_release", n, 0);

        // 4: long MODE to RUN, three shorts to SEC, clear, long back
        press(2'b01, 2'b11);
        chk("t4_long_run", int'(bus.o_field), 0);
        release_btns();
        repeat (3) begin
            press(2'b10, 2'b11);
            release_btns();
        end
        chk("t4_sec_field", int'(bus.o_field), 3);
        chk("t4_sec_run", int'(bus.o_run), 0);
        press(2'b11, 2'b10);
        chk("t4_sec_clr", int'(bus.o_sec_clr), 1);
        chk("t4_no_inc", int'(bus.o_inc), 0);
        release_btns();
        press(2'b01, 2'b11);
        chk("t4_back_field", int'(bus.o_field), 0);
        chk("t4_back_run", int'(bus.o_run), 1);
        chk("t4_back_blink", int'(bus.o_blink), 1);
        release_btns();

        // 5: idle timeout after 400 quiet cycles; ADJ at 399 restarts it
        press(2'b10, 2'b11);
        release_btns();
        wait_run(1, k);
        chk("t5_timeout_cycle", k, 400);
        press(2'b10, 2'b11);
        release_btns();
        repeat (397) tick();
        press(2'b11, 2'b10);
        chk("t5_adj399_inc", int'(bus.o_inc), 1);
        release_btns();
        chk("t5_still_hour", int'(bus.o_field), 1);
        wait_run(400, k);
        chk("t5_restart_cycle", k, 799);

        // 6: simultaneous events, then reset mid-repeat
        press(2'b10, 2'b11);
        release_btns();
        press(2'b10, 2'b10);
        chk("t6_both_field", int'(bus.o_field), 2);
        chk("t6_both_no_inc", int'(bus.o_inc), 0);
        release_btns();
        bus.i_adj_sw = 2'b00;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_field", int'(bus.o_field), 0);
        chk("t6_rst_outs", int'({bus.o_inc, bus.o_dec, bus.o_sec_clr,
                                 bus.o_run, bus.o_blink}), 3);
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            tick();
            n += int'(bus.o_inc);
        end
        chk("t6_no_pulse_after_rst", n, 0);
        chk("t6_field_after_rst", int'(bus.o_field), 0);
        release_btns();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
